// File: rtl/rect_pkg.sv
// Shared types and constants for the rectangle rasterizer.
package rect_pkg;

  localparam int COORD_W          = 11;
  localparam int DEFAULT_SCREEN_W = 640;
  localparam int DEFAULT_SCREEN_H = 480;

  // Rasterizer FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
  } rect_cmd_t;

endpackage

// File: rtl/rect_cmd_fifo.sv
// Synchronous command FIFO. A flush with a simultaneous push leaves exactly
// that pushed entry in the queue.
module rect_cmd_fifo
  import rect_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  rect_cmd_t              din,
  output rect_cmd_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic [CW-1:0] count_q, count_d;
  logic          mem_we, do_push, do_pop;
  rect_cmd_t     mem_q [DEPTH];

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty && !flush;
    do_push  = push && (flush || !full || do_pop);
    wr_addr  = flush ? '0 : wr_ptr_q;
    mem_we   = do_push;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = do_push ? AW'(1) : '0;
      count_d  = do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[wr_addr] <= din;
  end

endmodule

// File: rtl/rect_rasterizer.sv
// Queues rectangle commands and rasterizes them into one framebuffer write per
// clock; clearScreen flushes everything and sweeps the whole screen with 0.
module rect_rasterizer
  import rect_pkg::*;
#(
  parameter int N          = COORD_W,
  parameter int SCREEN_W   = DEFAULT_SCREEN_W,
  parameter int SCREEN_H   = DEFAULT_SCREEN_H,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] x0,
  input  logic [N-1:0] y0,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] y1,
  input  logic         wr,
  input  logic         clearScreen,
  output logic         cmd_ready,
  output logic [N-1:0] px,
  output logic [N-1:0] py,
  output logic         pixel_color,
  output logic         pixel_we,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam logic [N-1:0] X_MAX = N'(SCREEN_W - 1);
  localparam logic [N-1:0] Y_MAX = N'(SCREEN_H - 1);
  localparam logic [N-1:0] X_LIM = N'(SCREEN_W);
  localparam logic [N-1:0] Y_LIM = N'(SCREEN_H);

  // Handshake: a command is taken on a clock edge when wr && cmd_ready, or
  // unconditionally when wr coincides with clearScreen (it then becomes the
  // only queued entry). wr with cmd_ready low and no clearScreen is dropped.

  rect_cmd_t                    push_cmd, head;
  logic                         fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [N-1:0] xl_q, xl_d, xh_q, xh_d, yh_q, yh_d;
  logic [N-1:0] px_q, px_d, py_q, py_d;
  logic         color_q, color_d, we_q, we_d;
  logic [N-1:0] xl_c, xh_c, yl_c, yh_c, xh_raw, yh_raw;
  logic         discard_c, load;

  assign push_cmd  = {x0, y0, x1, y1};
  assign cmd_ready = !fifo_full;
  assign fifo_push = wr && (cmd_ready || clearScreen);

  rect_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (push_cmd),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Normalize and clip the head entry; only the high corner can be clamped.
  always_comb begin
    xl_c      = (head.x0 < head.x1) ? head.x0 : head.x1;
    xh_raw    = (head.x0 < head.x1) ? head.x1 : head.x0;
    yl_c      = (head.y0 < head.y1) ? head.y0 : head.y1;
    yh_raw    = (head.y0 < head.y1) ? head.y1 : head.y0;
    xh_c      = (xh_raw > X_MAX) ? X_MAX : xh_raw;
    yh_c      = (yh_raw > Y_MAX) ? Y_MAX : yh_raw;
    discard_c = (xl_c >= X_LIM) || (yl_c >= Y_LIM);
  end

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    xl_d       = xl_q;
    xh_d       = xh_q;
    yh_d       = yh_q;
    px_d       = px_q;
    py_d       = py_q;
    color_d    = color_q;
    we_d       = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    load       = 1'b0;
    if (clearScreen) begin
      fifo_flush = 1'b1;
      state_d    = ST_CLEAR;
      cx_d       = '0;
      cy_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: load = !fifo_empty;
        ST_FILL: begin
          we_d    = 1'b1;
          px_d    = cx_q;
          py_d    = cy_q;
          color_d = 1'b1;
          if (cx_q == xh_q) begin
            cx_d = xl_q;
            if (cy_q == yh_q) begin
              state_d = ST_IDLE;
              load    = !fifo_empty;
            end else begin
              cy_d = cy_q + N'(1);
            end
          end else begin
            cx_d = cx_q + N'(1);
          end
        end
        ST_CLEAR: begin
          we_d    = 1'b1;
          px_d    = cx_q;
          py_d    = cy_q;
          color_d = 1'b0;
          if (cx_q == X_MAX) begin
            cx_d = '0;
            if (cy_q == Y_MAX) state_d = ST_IDLE;
            else               cy_d    = cy_q + N'(1);
          end else begin
            cx_d = cx_q + N'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // Popping at the end of a fill keeps consecutive rectangles gap-free.
      if (load) begin
        fifo_pop = 1'b1;
        if (discard_c) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FILL;
          cx_d    = xl_c;
          cy_d    = yl_c;
          xl_d    = xl_c;
          xh_d    = xh_c;
          yh_d    = yh_c;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      xl_q    <= '0;
      xh_q    <= '0;
      yh_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      color_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xl_q    <= xl_d;
      xh_q    <= xh_d;
      yh_q    <= yh_d;
      px_q    <= px_d;
      py_q    <= py_d;
      color_q <= color_d;
      we_q    <= we_d;
    end
  end

  assign px          = px_q;
  assign py          = py_q;
  assign pixel_color = color_q;
  assign pixel_we    = we_q;
  assign busy        = (state_q != ST_IDLE) || (fifo_count != '0);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rect_rasterizer.sv
// Randomized and directed checks of rect_rasterizer on a 16x8 screen against a
// pixel-list reference model.
module tb_rect_rasterizer;

  localparam int N  = 11;
  localparam int SW = 16;
  localparam int SH = 8;
  localparam int PW = 2 * N + 1;

  logic         clock = 1'b0;
  logic         reset, wr, clearScreen;
  logic [N-1:0] x0, y0, x1, y1;
  logic         cmd_ready, pixel_color, pixel_we, busy;
  logic [N-1:0] px, py;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] obs_q[$];
  int            obs_t[$];

  rect_rasterizer #(.N(N), .SCREEN_W(SW), .SCREEN_H(SH), .FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .wr          (wr),
    .clearScreen (clearScreen),
    .cmd_ready   (cmd_ready),
    .px          (px),
    .py          (py),
    .pixel_color (pixel_color),
    .pixel_we    (pixel_we),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / monitor ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (pixel_we) begin
      obs_q.push_back({px, py, pixel_color});
      obs_t.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] pk(input int x, input int y, input logic c);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    return {xv[N-1:0], yv[N-1:0], c};
  endfunction

  function automatic void model_rect(input int ax0, input int ay0, input int ax1, input int ay1);
    int xl, xh, yl, yh;
    xl = (ax0 < ax1) ? ax0 : ax1;
    xh = (ax0 < ax1) ? ax1 : ax0;
    yl = (ay0 < ay1) ? ay0 : ay1;
    yh = (ay0 < ay1) ? ay1 : ay0;
    if (xh > SW - 1) xh = SW - 1;
    if (yh > SH - 1) yh = SH - 1;
    if (xl >= SW || yl >= SH) return;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++)
        exp_q.push_back(pk(x, y, 1'b1));
  endfunction

  function automatic void model_clear();
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++)
        exp_q.push_back(pk(x, y, 1'b0));
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_cmd(input int ax0, input int ay0, input int ax1, input int ay1);
    x0 = ax0[N-1:0];
    y0 = ay0[N-1:0];
    x1 = ax1[N-1:0];
    y1 = ay1[N-1:0];
    wr = 1'b1;
    @(negedge clock);
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!busy && !pixel_we) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    obs_t.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (pixel_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", pixel_we); end
    checks++; if (px !== '0 || py !== '0) begin failures++; $display("FAIL reset_xy got=%0d,%0d want=0,0", px, py); end
    checks++; if (pixel_color !== 1'b0) begin failures++; $display("FAIL reset_color got=%b want=0", pixel_color); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0 || pixel_we !== 1'b0) begin failures++; $display("FAIL post_reset_idle got busy=%b we=%b want 0,0", busy, pixel_we); end
  endtask

  task automatic test_single();
    bit ok;
    int a;
    clear_queues();
    model_rect(2, 1, 4, 2);
    a = cyc;
    drive_cmd(2, 1, 4, 2);
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=busy want=idle"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL single_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL single_pixel[%0d] got=%0d,%0d,%0b want=%0d,%0d,%0b", i, obs_q[i][PW-1:N+1], obs_q[i][N:1], obs_q[i][0], exp_q[i][PW-1:N+1], exp_q[i][N:1], exp_q[i][0]);
      end
    end
    if (obs_t.size() > 0) begin
      checks++; if (obs_t[0] != a + 3) begin failures++; $display("FAIL single_latency got=%0d want=%0d", obs_t[0] - a - 1, 2); end
      checks++; if (obs_t[obs_t.size()-1] - obs_t[0] != obs_t.size() - 1) begin failures++; $display("FAIL single_contiguous got span=%0d want=%0d", obs_t[obs_t.size()-1] - obs_t[0], obs_t.size() - 1); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_swap_clip();
    int tbl [3][4];
    bit ok;
    tbl[0] = '{4, 2, 2, 1};
    tbl[1] = '{14, 6, 20, 9};
    tbl[2] = '{16, 0, 18, 3};
    for (int k = 0; k < 3; k++) begin
      clear_queues();
      model_rect(tbl[k][0], tbl[k][1], tbl[k][2], tbl[k][3]);
      drive_cmd(tbl[k][0], tbl[k][1], tbl[k][2], tbl[k][3]);
      wait_idle(200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL swapclip%0d_timeout got=busy want=idle", k); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL swapclip%0d_count got=%0d want=%0d", k, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL swapclip%0d_pixel[%0d] got=%0d,%0d,%0b want=%0d,%0d,%0b", k, i, obs_q[i][PW-1:N+1], obs_q[i][N:1], obs_q[i][0], exp_q[i][PW-1:N+1], exp_q[i][N:1], exp_q[i][0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic rdy;
    clear_queues();
    model_rect(0, 0, 15, 7);
    drive_cmd(0, 0, 15, 7);
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b want=1", busy); end
    for (int k = 0; k < 5; k++) begin
      rdy = cmd_ready;
      checks++;
      if (rdy !== (k < 4)) begin failures++; $display("FAIL b2b_ready[%0d] got=%b want=%b", k, rdy, (k < 4)); end
      if (rdy) model_rect(k, 0, k + 1, 1);
      drive_cmd(k, 0, k + 1, 1);
    end
    wait_idle(600, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=busy want=idle"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_pixel[%0d] got=%0d,%0d,%0b want=%0d,%0d,%0b", i, obs_q[i][PW-1:N+1], obs_q[i][N:1], obs_q[i][0], exp_q[i][PW-1:N+1], exp_q[i][N:1], exp_q[i][0]);
      end
    end
    if (obs_t.size() > 0) begin
      checks++; if (obs_t[obs_t.size()-1] - obs_t[0] != obs_t.size() - 1) begin failures++; $display("FAIL b2b_contiguous got span=%0d want=%0d", obs_t[obs_t.size()-1] - obs_t[0], obs_t.size() - 1); end
    end
  endtask

  task automatic test_clear_idle();
    bit ok;
    int a;
    clear_queues();
    model_clear();
    a = cyc;
    clearScreen = 1'b1;
    @(negedge clock);
    clearScreen = 1'b0;
    wait_idle(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL clear_timeout got=busy want=idle"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL clear_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL clear_pixel[%0d] got=%0d,%0d,%0b want=%0d,%0d,%0b", i, obs_q[i][PW-1:N+1], obs_q[i][N:1], obs_q[i][0], exp_q[i][PW-1:N+1], exp_q[i][N:1], exp_q[i][0]);
      end
    end
    if (obs_t.size() > 0) begin
      checks++; if (obs_t[0] != a + 2) begin failures++; $display("FAIL clear_latency got=%0d want=%0d", obs_t[0], a + 2); end
      checks++; if (obs_t[obs_t.size()-1] - obs_t[0] != obs_t.size() - 1) begin failures++; $display("FAIL clear_contiguous got span=%0d want=%0d", obs_t[obs_t.size()-1] - obs_t[0], obs_t.size() - 1); end
    end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL clear_end got busy=%b ready=%b want 0,1", busy, cmd_ready); end
  endtask

  task automatic test_clear_mid_fill();
    bit ok;
    int a, nq;
    logic [PW-1:0] got[$];
    int got_t[$];
    for (int pass = 0; pass < 2; pass++) begin
      nq = (pass == 0) ? 2 : 4;
      clear_queues();
      got.delete();
      got_t.delete();
      drive_cmd(0, 0, 15, 7);
      for (int q = 0; q < nq; q++) drive_cmd(q, 1, q + 2, 3);
      checks++;
      if (cmd_ready !== (nq < 4)) begin failures++; $display("FAIL midclear%0d_ready got=%b want=%b", nq, cmd_ready, (nq < 4)); end
      repeat (5) @(negedge clock);
      model_clear();
      model_rect(0, 0, 1, 0);
      a = cyc;
      clearScreen = 1'b1;
      x0 = '0; y0 = '0; x1 = 11'd1; y1 = '0;
      wr = 1'b1;
      @(negedge clock);
      clearScreen = 1'b0;
      wr = 1'b0;
      wait_idle(600, ok);
      checks++; if (!ok) begin failures++; $display("FAIL midclear%0d_timeout got=busy want=idle", nq); end
      for (int i = 0; i < obs_q.size(); i++) begin
        if (obs_t[i] > a) begin
          got.push_back(obs_q[i]);
          got_t.push_back(obs_t[i]);
        end
      end
      checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL midclear%0d_count got=%0d want=%0d", nq, got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL midclear%0d_pixel[%0d] got=%0d,%0d,%0b want=%0d,%0d,%0b", nq, i, got[i][PW-1:N+1], got[i][N:1], got[i][0], exp_q[i][PW-1:N+1], exp_q[i][N:1], exp_q[i][0]);
        end
      end
      if (got_t.size() >= SW * SH) begin
        checks++; if (got_t[0] != a + 2) begin failures++; $display("FAIL midclear%0d_latency got=%0d want=%0d", nq, got_t[0], a + 2); end
        checks++; if (got_t[SW*SH-1] - got_t[0] != SW * SH - 1) begin failures++; $display("FAIL midclear%0d_contiguous got span=%0d want=%0d", nq, got_t[SW*SH-1] - got_t[0], SW * SH - 1); end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int c0, c1, c2, c3;
    logic rdy;
    clear_queues();
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clock);
      c0 = $urandom_range(0, 20);
      c1 = $urandom_range(0, 20);
      c2 = $urandom_range(0, 20);
      c3 = $urandom_range(0, 20);
      rdy = cmd_ready;
      if (rdy) model_rect(c0, c1, c2, c3);
      drive_cmd(c0, c1, c2, c3);
    end
    wait_idle(5000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL random_timeout got=busy want=idle"); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL random_pixel[%0d] got=%0d,%0d,%0b want=%0d,%0d,%0b", i, obs_q[i][PW-1:N+1], obs_q[i][N:1], obs_q[i][0], exp_q[i][PW-1:N+1], exp_q[i][N:1], exp_q[i][0]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int a, late;
    clear_queues();
    clearScreen = 1'b1;
    @(negedge clock);
    clearScreen = 1'b0;
    repeat (2) @(negedge clock);
    drive_cmd(1, 1, 3, 3);
    drive_cmd(5, 2, 6, 4);
    repeat (10) @(negedge clock);
    checks++; if (busy !== 1'b1 || pixel_we !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got busy=%b we=%b want 1,1", busy, pixel_we); end
    a = cyc;
    reset = 1'b1;
    clearScreen = 1'b1;
    @(negedge clock);
    checks++; if (pixel_we !== 1'b0) begin failures++; $display("FAIL rst_mid_we got=%b want=0", pixel_we); end
    checks++; if (px !== '0 || py !== '0) begin failures++; $display("FAIL rst_mid_xy got=%0d,%0d want=0,0", px, py); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b want=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    reset = 1'b0;
    clearScreen = 1'b0;
    repeat (10) @(negedge clock);
    late = 0;
    for (int i = 0; i < obs_t.size(); i++) if (obs_t[i] > a) late++;
    checks++; if (late != 0) begin failures++; $display("FAIL rst_mid_writes got=%0d want=0", late); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_idle got=%b want=0", busy); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    wr = 1'b0;
    clearScreen = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    test_reset();
    test_single();
    test_swap_clip();
    test_back_to_back();
    test_clear_idle();
    test_clear_mid_fill();
    test_random();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rect_rasterizer.md
# rect_rasterizer

Consumer end of the rectangle command stream produced by the game's buffer-control block. Accepts rectangle commands (corner coordinates plus write strobe) and frame clear requests. Queues commands, then rasterizes each one into a stream of single-pixel framebuffer writes, one pixel per clock. Sits between the game-logic side and the framebuffer/VGA memory.

## Interface
- N, 11, coordinate width for all x/y buses
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- FIFO_DEPTH, 4, command queue depth (power of two, ≥2)
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- x0, y0, x1, y1  in  N each  rectangle corners, inclusive, any order
- wr  in  1  command valid; accepted on a clock edge when wr && cmd_ready
- clearScreen  in  1  single-cycle frame clear request
- cmd_ready  out  1  high when the FIFO is not full
- px, py  out  N each  pixel address, registered
- pixel_color  out  1  1 = draw, 0 = clear
- pixel_we  out  1  pixel write strobe, registered
- busy  out  1  high in CLEAR or FILL, or when the FIFO is non-empty

## Operation
- States: IDLE, CLEAR, FILL.
- Commands are stored as {x0,y0,x1,y1} in the FIFO. Normalization happens at pop: xl=min(x0,x1), xh=max(x0,x1); yl/yh the same way.
- Clipping at pop: xh clamps to SCREEN_W-1 and yh clamps to SCREEN_H-1. If xl≥SCREEN_W or yl≥SCREEN_H, the command is discarded with no pixels and no FILL cycles.
- IDLE with FIFO non-empty: pop the head and go to FILL, with cx=xl, cy=yl.
- FILL: each cycle emit (cx,cy) with color 1. Scan is row-major, x fastest.
  - At cx==xh: cx←xl, cy←cy+1.
  - At (xh,yh): back to IDLE. Pop the next entry in the same cycle if available, so there are no gap cycles between rectangles.
- CLEAR: emit every pixel (0,0)…(SCREEN_W-1,SCREEN_H-1) with color 0, row-major, then go to IDLE.
- clearScreen takes effect in any state and has priority over everything else. On the next cycle:
  - the FIFO is flushed;
  - any FILL in progress is aborted;
  - the sweep restarts at (0,0).
- A wr on the same cycle as clearScreen is accepted unconditionally, including when cmd_ready=0. It becomes the sole FIFO entry.
- wr while cmd_ready=0 (without clearScreen): the command is dropped. No other state changes.
- Coordinate counters are N bits wide. Comparisons are unsigned, and no wrap-around is possible after clamping.

## Timing
- Reset values:
  - px=0, py=0, pixel_color=0, pixel_we=0;
  - cmd_ready=1, busy=0;
  - state IDLE, FIFO empty.
- Reset has priority over clearScreen. Reset mid-FILL or mid-CLEAR aborts immediately, and no pixel_we is asserted on the cycle after reset.
- Command accepted at edge t into an empty FIFO while IDLE: popped at t+1, first pixel_we high after edge t+2.
- A w×h rectangle occupies exactly w·h consecutive pixel_we cycles.
- CLEAR occupies exactly SCREEN_W·SCREEN_H pixel_we cycles. The first write follows the edge after clearScreen is sampled.
- cmd_ready is combinational from the FIFO count. A push and a pop on the same edge with the FIFO full is allowed; the count is unchanged.
- pixel_we is low in IDLE and in discard cycles.

## Structure
- Package rect_pkg holds:
  - the state enum (IDLE, CLEAR, FILL);
  - the rect_cmd_t struct {x0,y0,x1,y1};
  - the default SCREEN_W/SCREEN_H constants.
- Sub-module rect_cmd_fifo is a synchronous FIFO of rect_cmd_t with push, pop, flush, full, empty and count. The rasterizer FSM and counters live in rect_rasterizer.

## Test plan
Benches use SCREEN_W=16, SCREEN_H=8, FIFO_DEPTH=4.
- Reset, then wr with (2,1,4,2): 6 pixel_we cycles, in order (2,1)(3,1)(4,1)(2,2)(3,2)(4,2), color 1, first write 2 cycles after accept. busy then drops.
- Swapped corners (4,2,2,1): identical 6-pixel sequence. Command (14,6,20,9): clipped to (14,6)-(15,7), 4 pixels. Command (16,0,18,3): no pixel_we.
- Five back-to-back wr while busy: cmd_ready drops after the 4th push outstanding, the 5th is dropped, and the rectangles are drawn back-to-back with no idle cycles.
- clearScreen in IDLE: exactly 128 writes (0,0)…(15,7) with color 0, then busy=0.
- clearScreen mid-FILL with 2 queued commands: the fill aborts, the queue is flushed, and a 128-pixel clear follows. A wr on the clear cycle with (0,0,1,0) is drawn after the clear (2 pixels).
- Reset asserted mid-CLEAR: the next cycle has pixel_we=0, px=py=0, cmd_ready=1, busy=0, and the FIFO is empty.
